// File: rtl/versus_link_pkg.sv
// Shared types and constants for the two-player status link transmitter.
package versus_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  localparam int BIT_IDX_W  = $clog2(DATA_BITS);

  // Status payload layout: {STATE, RESULT, HP}
  localparam int STATE_LSB  = 4;
  localparam int STATE_W    = 4;
  localparam int RESULT_LSB = 2;
  localparam int RESULT_W   = 2;
  localparam int HP_LSB     = 0;
  localparam int HP_W       = 2;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/link_baud_gen.sv
// Bit-period counter: bit_end marks the last clock of each serial bit.
module link_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Held in clear while idle, so the first bit of a frame gets a full period.
  assign bit_end = (cnt == LAST) && !clr;

endmodule

// File: rtl/versus_link_tx.sv
// UART-style status transmitter: start, 8 data bits LSB first, even parity, stop,
// with a one-entry pending buffer so an update arriving mid-frame is not lost.
module versus_link_tx
  import versus_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SEND,
  input  logic [DATA_BITS-1:0] PAYLOAD,
  output logic                 TXD,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 OVERRUN
);

  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

  state_t                 state, state_n;
  logic [BIT_IDX_W-1:0]   idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic [DATA_BITS-1:0]   pend_data, pend_data_n;
  logic [DATA_BITS-1:0]   next_frame;
  logic                   par, par_n;
  logic                   pend_full, pend_full_n;
  logic                   ovr_n;
  logic                   txd_n;
  logic                   bit_end;
  logic                   stop_end;

  link_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (CLK),
    .rst     (RST),
    .clr     (state == IDLE),
    .bit_end (bit_end)
  );

  assign stop_end   = (state == STOP) && bit_end;
  // At the end of a stop bit the pending entry has priority over a fresh SEND.
  assign next_frame = pend_full ? pend_data : PAYLOAD;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    shreg_n     = shreg;
    par_n       = par;
    pend_full_n = pend_full;
    pend_data_n = pend_data;
    ovr_n       = 1'b0;

    case (state)
      IDLE: begin
        if (SEND) begin
          shreg_n = PAYLOAD;
          par_n   = even_parity(PAYLOAD);
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          idx_n   = idx + BIT_IDX_W'(1);
          if (idx == LAST_IDX) begin
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (pend_full || SEND) begin
            shreg_n     = next_frame;
            par_n       = even_parity(next_frame);
            pend_full_n = 1'b0;
            state_n     = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Consume-then-store: a SEND at stop end refills the slot just emptied.
    if (SEND && (state != IDLE)) begin
      if (stop_end) begin
        if (pend_full) begin
          pend_full_n = 1'b1;
          pend_data_n = PAYLOAD;
        end
      end else if (pend_full) begin
        ovr_n = 1'b1;
      end else begin
        pend_full_n = 1'b1;
        pend_data_n = PAYLOAD;
      end
    end

    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[0];
      PARITY:  txd_n = par_n;
      default: txd_n = 1'b1;
    endcase
  end

  // ---- control registers ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      pend_full <= 1'b0;
      OVERRUN   <= 1'b0;
      TXD       <= 1'b1;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      pend_full <= pend_full_n;
      OVERRUN   <= ovr_n;
      TXD       <= txd_n;
    end
  end

  // ---- data registers ----
  always_ff @(posedge CLK) begin
    shreg     <= shreg_n;
    par       <= par_n;
    pend_data <= pend_data_n;
  end

  assign BUSY = (state != IDLE) || pend_full;
  assign DONE = stop_end;

endmodule
